// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release controller with PLL lock tracking and soft reset
//
// Releases one active-low reset per subsystem in order (0 = memory/framebuffer,
// 1 = pixel pipeline, 2 = VGA timing, 3 = output driver), spaced STAGE_DELAY
// cycles apart once the PLL lock is stable. Re-sequences on lock loss or on a
// software soft-reset request.
//
// Ports:
//   clock        pixel-domain clock
//   reset_n      asynchronous active-low reset (deasserted synchronously upstream)
//   lock         raw PLL lock, asynchronous; double-flopped internally
//   soft_req     level soft-reset request, held until soft_ack is seen
//   soft_ack     soft-reset hold period completed
//   stage_rst_n  per-stage active-low resets, bit i released before bit i+1
//   all_ready    every stage released and sequencer in RUN
//   state        debug: HOLD=0, RELEASE=1, RUN=2, ASSERT=3
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int SOFT_HOLD   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lock,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_ready,
  output logic [1:0]            state
);

  localparam int CNT_MAX = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_ASSERT  = 2'd3
  } seq_state_t;

  seq_state_t       cur_state;
  logic             lock_meta;
  logic             lock_sync;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] stage_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_sync <= lock_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= S_HOLD;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      soft_ack    <= 1'b0;
      count       <= '0;
      stage_idx   <= '0;
    end else if (cur_state != S_HOLD && !lock_sync) begin
      // Lock loss outranks everything, including a pending soft request.
      cur_state   <= S_HOLD;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      soft_ack    <= 1'b0;
      count       <= '0;
      stage_idx   <= '0;
    end else begin
      case (cur_state)
        S_HOLD: begin
          // The count only advances over an unbroken run of lock_sync=1.
          if (!lock_sync) begin
            count <= '0;
          end else if (count == DELAY_LAST) begin
            stage_rst_n <= NUM_STAGES'(1);
            stage_idx   <= IDX_W'(1);
            count       <= '0;
            if (NUM_STAGES == 1) begin
              cur_state <= S_RUN;
              all_ready <= 1'b1;
            end else begin
              cur_state <= S_RELEASE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        S_RELEASE: begin
          if (count == DELAY_LAST) begin
            // Released bits are contiguous from bit 0, so a shift-in of 1
            // releases exactly stage_idx.
            stage_rst_n <= (stage_rst_n << 1) | NUM_STAGES'(1);
            stage_idx   <= stage_idx + 1'b1;
            count       <= '0;
            if (stage_idx == IDX_LAST) begin
              cur_state <= S_RUN;
              all_ready <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        S_RUN: begin
          if (soft_req) begin
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            count       <= '0;
            cur_state   <= S_ASSERT;
          end
        end

        S_ASSERT: begin
          // Once acknowledged, the count parks at SOFT_HOLD; a request that
          // dropped early still gets the full hold and a one-cycle ack.
          if (soft_ack) begin
            if (!soft_req) begin
              soft_ack  <= 1'b0;
              count     <= '0;
              stage_idx <= '0;
              cur_state <= S_HOLD;
            end
          end else if (count == HOLD_LAST) begin
            soft_ack <= 1'b1;
            count    <= count + 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        default: cur_state <= S_HOLD;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller for the video controller. It sits behind the board-level reset synchronizer and takes the synchronized `reset_n` plus the raw PLL `lock`. It releases one active-low reset per subsystem in a fixed order, spaced by a programmable delay: stage 0 = memory/framebuffer, 1 = pixel pipeline, 2 = VGA timing, 3 = output driver. It also re-sequences on PLL lock loss or on a software-requested soft reset.

## Interface
- `NUM_STAGES`, default 4: number of sequenced reset outputs; legal range 1..8.
- `STAGE_DELAY`, default 16: clock cycles between successive stage releases, and from lock-stable to stage 0; must be at least 2.
- `SOFT_HOLD`, default 8: minimum number of cycles all stages are held in reset during a soft reset; must be at least 1.
- Internal counter width is derived from max(`STAGE_DELAY`, `SOFT_HOLD`); it is not a parameter.

Ports:
- `clock` in 1: pixel-domain clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset. It asserts asynchronously and is deasserted synchronously upstream.
- `lock` in 1: PLL lock, asynchronous to `clock`. It is double-flopped internally (`lock_sync`, 2-cycle latency).
- `soft_req` in 1: level request for a soft reset. Held high until `soft_ack` is seen.
- `soft_ack` out 1: soft reset hold completed.
- `stage_rst_n` out `NUM_STAGES`: per-stage active-low resets. Bit i is released before bit i+1.
- `all_ready` out 1: all stages released and the sequencer is in RUN.
- `state` out 2: debug encoding, HOLD=0, RELEASE=1, RUN=2, ASSERT=3.

## Operation
- All outputs are registered. During `reset_n`=0: state=HOLD, `stage_rst_n`=all 0, `all_ready`=0, `soft_ack`=0, counter=0, stage index=0, lock synchronizer=0.
- **HOLD:**
  - While `lock_sync`=0, the counter is held at 0.
  - While `lock_sync`=1, the counter increments each cycle.
  - On the `STAGE_DELAY`-th consecutive cycle with `lock_sync`=1: set `stage_rst_n[0]`=1, index←1, counter←0.
  - Next state is RELEASE, or RUN directly if `NUM_STAGES`=1.
- **RELEASE:**
  - The counter increments each cycle.
  - On the `STAGE_DELAY`-th cycle: set `stage_rst_n[index]`=1, increment index, clear counter.
  - When the stage just released is `NUM_STAGES`-1, the same edge sets state=RUN and `all_ready`=1.
- **RUN:** outputs are held. `soft_req`=1 causes the next edge to set `stage_rst_n`=all 0, `all_ready`=0, counter←0, state=ASSERT.
- **ASSERT:**
  - The counter increments.
  - Once the counter reaches `SOFT_HOLD`, `soft_ack`←1 and stays 1 while `soft_req`=1.
  - When `soft_ack`=1 and `soft_req`=0: `soft_ack`←0, counter←0, index←0, state=HOLD, and the normal sequence restarts.
  - `soft_req` dropping before `soft_ack` does not shorten the hold. The full `SOFT_HOLD` period elapses, `soft_ack` pulses for 1 cycle, then the block returns to HOLD.
- **Lock loss:** `lock_sync`=0 in RELEASE, RUN or ASSERT causes the next edge to set `stage_rst_n`=all 0, `all_ready`=0, `soft_ack`=0, counter=0, index=0, state=HOLD.
  - Lock loss has priority over every other event, including a simultaneous `soft_req`.
- `soft_req` is ignored in HOLD and RELEASE. If still high on reaching RUN, it is honoured on the first RUN cycle.
- Released bits never return to 0 except by lock loss, soft reset, or `reset_n`.

## Timing
- Let edge 0 be the first rising edge at which `lock_sync`=1; this is 2 edges after `lock` rises.
- `stage_rst_n[i]` rises at edge (i+1)·`STAGE_DELAY`. `all_ready` rises at edge `NUM_STAGES`·`STAGE_DELAY`, the same edge as the last stage.
- Defaults give stages at edges 16, 32, 48, 64, with `all_ready` at edge 64.
- Soft reset, with `soft_req` seen high in RUN at edge s:
  - resets assert at s+1;
  - `soft_ack` rises at s+1+`SOFT_HOLD`;
  - if `soft_req` falls and is sampled low at edge t, then HOLD is entered at t+1 and stage 0 releases at t+1+`STAGE_DELAY`, provided lock holds.
- Lock loss: `lock` low produces `lock_sync` low 2 edges later, and outputs clear 1 edge after that; 3 edges worst case.
- `reset_n` assertion clears all outputs asynchronously, with no clock required.

## Test plan
- Power-up, default parameters: hold `lock`=1, release `reset_n` → `stage_rst_n` steps 0001, 0011, 0111, 1111 at edges 16, 32, 48, 64 after `lock_sync`; `all_ready`=1 at edge 64; state reads 0→1→2.
- Lock glitch in HOLD: `lock` low for 3 cycles at edge 10 → counter restarts; stage 0 releases 16 edges after `lock_sync` returns high; no early release.
- Lock loss mid-RELEASE at edge 40 (stages 0b0011) → all 0 within 3 edges; state=0; full sequence repeats on relock.
- Soft reset in RUN: `soft_req`=1 → resets all 0 next edge; `soft_ack` after 8 cycles; drop `soft_req` → `soft_ack` 0; re-sequence at 16/32/48/64 cycles.
- `soft_req` and lock loss on the same edge in RUN → HOLD with `soft_ack`=0. `soft_req` held through relock → honoured on the first RUN cycle.
- Asynchronous `reset_n` pulse mid-ASSERT (between clock edges) → all outputs 0 immediately; state=0.
